muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and datapath constants.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int          STEPS   = 32;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude extraction on operands
// and sign correction on results. Ports: value in, neg in, mag out.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] mag
);

  assign mag = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring divide.
// Ports: clk, rst, start, op, rs1_data, rs2_data, flush -> busy, done, result.
// Macro MULDIV_DIV_EN builds the divider; without it div ops return 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] LAST = 5'(STEPS - 1);

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] p, p_step;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN:0]     acc;
  logic              sign_a, sign_b;
  logic              neg_a, neg_b, neg_res;
  logic              is_div, special, accept;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   spec_res, fin_res;

  // operand signedness by funct3
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      OP_MULHSU: sign_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a  = sign_a & rs1_data[XLEN-1];
  assign neg_b  = sign_b & rs2_data[XLEN-1];
  assign is_div = op[2];
  // remainder follows the dividend; product/quotient follow sign xor
  assign neg_res = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);

  muldiv_signfix #(.W(XLEN)) u_mag_a (
    .value (rs1_data),
    .neg   (neg_a),
    .mag   (mag_a)
  );

  muldiv_signfix #(.W(XLEN)) u_mag_b (
    .value (rs2_data),
    .neg   (neg_b),
    .mag   (mag_b)
  );

  // single-edge cases that bypass CALC
  always_comb begin
`ifdef MULDIV_DIV_EN
    special  = 1'b0;
    spec_res = '0;
    if (is_div && rs2_data == '0) begin
      special  = 1'b1;
      spec_res = op[1] ? rs1_data : '1;
    end else if ((op == OP_DIV || op == OP_REM) &&
                 rs1_data == INT_MIN && rs2_data == '1) begin
      special  = 1'b1;
      spec_res = op[1] ? '0 : INT_MIN;
    end
`else
    special  = is_div;
    spec_res = '0;
`endif
  end

  assign accept = start & ~flush &
                  (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = special ? S_DONE : S_CALC;
        else        state_nxt = S_IDLE;
      end
      S_CALC: if (cnt == LAST) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    busy = (state == S_CALC);
    done = (state == S_DONE);
  end

  // one iteration step; p holds {hi, lo} for mul, {rem, quot} for div
  always_comb begin
    acc    = {1'b0, p[2*XLEN-1:XLEN]} +
             (p[0] ? {1'b0, m_q} : '0);
    p_step = {acc, p[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    begin : div_step
      logic [XLEN:0]   shl;
      logic [XLEN-1:0] dif;
      logic            ge;
      shl = {p[2*XLEN-1:XLEN], p[XLEN-1]};
      ge  = shl >= {1'b0, m_q};
      dif = shl[XLEN-1:0] - m_q;
      if (op_q[2]) begin
        p_step = ge ? {dif, p[XLEN-2:0], 1'b1}
                    : {shl[XLEN-1:0], p[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    fix_in = p_step;
    if (op_q[2]) begin
      fix_in = {{XLEN{1'b0}},
                op_q[1] ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0]};
    end
  end

  muldiv_signfix #(.W(2*XLEN)) u_fix (
    .value (fix_in),
    .neg   (neg_q),
    .mag   (fix_out)
  );

  assign fin_res = (op_q[2] || op_q == OP_MUL) ?
                   fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      m_q    <= '0;
      p      <= '0;
      result <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op;
      neg_q <= neg_res;
      if (is_div) begin
        p   <= {{XLEN{1'b0}}, mag_a};
        m_q <= mag_b;
      end else begin
        p   <= {{XLEN{1'b0}}, mag_b};
        m_q <= mag_a;
      end
      if (special) result <= spec_res;
    end else if (state == S_CALC && !flush) begin
      p   <= p_step;
      cnt <= cnt + 5'd1;
      if (cnt == LAST) result <= fin_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops against
// an arithmetic reference model, plus flush, reset and collision cases.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // {special, result} from plain 64-bit arithmetic
  function automatic logic [32:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, pr;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (o)
      OP_MUL:    begin pr = ea * eb; return {1'b0, pr[31:0]}; end
      OP_MULH:   begin pr = ea * eb; return {1'b0, pr[63:32]}; end
      OP_MULHSU: begin
        pr = ea * {32'd0, b};
        return {1'b0, pr[63:32]};
      end
      OP_MULHU:  begin
        pr = {32'd0, a} * {32'd0, b};
        return {1'b0, pr[63:32]};
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 0) return {1'b1, (o[1] ? a : 32'hFFFF_FFFF)};
        if (!o[0] && a == INT_MIN && b == 32'hFFFF_FFFF)
          return {1'b1, (o[1] ? 32'd0 : INT_MIN)};
        case (o)
          OP_DIV:  return {1'b0, 32'($signed(a) / $signed(b))};
          OP_REM:  return {1'b0, 32'($signed(a) % $signed(b))};
          OP_DIVU: return {1'b0, a / b};
          default: return {1'b0, a % b};
        endcase
`else
        return {1'b1, 32'd0};
`endif
      end
    endcase
  endfunction

  // issue one op; inj>0 pulses a conflicting start at that sample
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input string tag,
                        input int inj);
    logic [32:0] m;
    int n, nb;
    m = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (n == inj) begin
        start = 1'b1; op = OP_MULHU; rs1 = ~a; rs2 = ~b;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), m[32] ? 32'd1 : 32'd33);
    chk({tag, " busy_cycles"}, 32'(nb), m[32] ? 32'd0 : 32'd32);
    chk({tag, " result"}, result, m[31:0]);
    last_res = m[31:0];
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int cnt_ev;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; rs1 = '0; rs2 = '0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, "mul_7_m3", 0);
    run_op(OP_MULH, INT_MIN, INT_MIN, "mulh_min", 0);
    run_op(OP_MULHU, '1, '1, "mulhu_ff", 0);
    run_op(OP_MULHSU, '1, 32'd2, "mulhsu_m1_2", 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 0);
    run_op(OP_REMU, 32'd100, 32'd7, "remu_100_7", 0);
    run_op(OP_DIVU, 32'd5, 32'd0, "divu_by0", 0);
    run_op(OP_REM, 32'd5, 32'd0, "rem_by0", 0);
    run_op(OP_DIV, INT_MIN, '1, "div_ovf", 0);
    run_op(OP_REM, INT_MIN, '1, "rem_ovf", 0);
    run_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, "mid_start", 5);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ra = INT_MIN; rb = '1;
      end
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 0);
    end

    // flush with counter at 10
    @(negedge clk);
    start = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    cnt_ev = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) cnt_ev++;
    end
    chk("flush no_done", 32'(cnt_ev), 32'd0);
    chk("flush result_kept", result, last_res);

    // start and flush together in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULHU; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    cnt_ev = 0;
    repeat (40) begin
      if (done || busy) cnt_ev++;
      @(posedge clk); #1;
    end
    chk("start_flush no_accept", 32'(cnt_ev), 32'd0);
    chk("start_flush result", result, last_res);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = OP_MUL; rs1 = 32'd11; rs2 = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid result", result, 32'd0);
    @(negedge clk) rst = 1'b0;
    cnt_ev = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) cnt_ev++;
    end
    chk("rst_mid no_done", 32'(cnt_ev), 32'd0);

    run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D, "after_rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
